// File: rtl/pipe_reg_elastic.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_elastic
// Brief    : Elastic inter-stage pipeline register, DEPTH stages of WORD_LEN
//            bits, with per-stage valid bits, valid/ready handshake, bubble
//            collapsing, synchronous flush, occupancy reporting and a
//            saturating backpressure stall counter.
// Options  : PIPE_REG_ZERO_ON_FLUSH_EN - when defined, data registers are
//            cleared on flush and whenever a stage loads a bubble, so that
//            out_data reads 0 whenever out_valid is 0. When undefined, data
//            registers only load valid beats (clock-gating friendly) and
//            out_data is don't-care while out_valid is 0.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_reg_elastic #(
    parameter int WORD_LEN    = 32,
    parameter int DEPTH       = 2,
    parameter int STALL_CNT_W = 16,
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_LEN-1:0]    in_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LEN-1:0]    out_data,
    output logic [CNT_W-1:0]       occupancy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [STALL_CNT_W-1:0] c_STALL_MAX = '1;

    // Stage state: index 0 is the input stage, DEPTH-1 drives the outputs.
    logic [DEPTH-1:0]       r_v;
    logic [WORD_LEN-1:0]    r_d [DEPTH];
    logic [CNT_W-1:0]       r_occ;
    logic [STALL_CNT_W-1:0] r_stall;

    // Per-stage load enables and the value each stage would load.
    logic [DEPTH-1:0]       w_en;
    logic [DEPTH-1:0]       w_src_v;
    logic [WORD_LEN-1:0]    w_src_d [DEPTH];
    logic [DEPTH-1:0]       w_v_nxt;
    logic [CNT_W-1:0]       w_occ_nxt;
    logic                   w_accept;
    logic                   w_stall_evt;

    // Enable chain, evaluated from the output backwards: a stage may load
    // when downstream accepts or when it or any stage ahead of it is empty.
    // Accumulating in one variable keeps the chain free of vector self-loops.
    always_comb begin : p_en_chain
        logic l_carry;
        l_carry = out_ready;
        w_en    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            l_carry = l_carry | ~r_v[i];
            w_en[i] = l_carry;
        end
    end

    assign in_ready = w_en[0] & ~flush;
    assign w_accept = in_valid & in_ready;

    // Source of each stage: stage 0 takes the upstream beat, every other
    // stage takes the contents of the stage behind it.
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_stage_src
            if (g == 0) begin : g_head
                assign w_src_v[g] = w_accept;
                assign w_src_d[g] = in_data;
            end else begin : g_link
                assign w_src_v[g] = r_v[g-1];
                assign w_src_d[g] = r_d[g-1];
            end
        end
    endgenerate

    // Next-state valid bits and their population count for occupancy.
    always_comb begin
        w_v_nxt   = '0;
        w_occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                w_v_nxt[i] = 1'b0;
            end else if (w_en[i]) begin
                w_v_nxt[i] = w_src_v[i];
            end else begin
                w_v_nxt[i] = r_v[i];
            end
            w_occ_nxt = w_occ_nxt + CNT_W'(w_v_nxt[i]);
        end
    end

    // Valid bits and occupancy register; reset outranks flush and handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v   <= '0;
            r_occ <= '0;
        end else begin
            r_v   <= w_v_nxt;
            r_occ <= w_occ_nxt;
        end
    end

    // Data registers: load policy for bubbles and flush depends on the option.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef PIPE_REG_ZERO_ON_FLUSH_EN
                if (flush) begin
                    r_d[i] <= '0;
                end else if (w_en[i]) begin
                    r_d[i] <= w_src_v[i] ? w_src_d[i] : '0;
                end
`else
                if (!flush && w_en[i] && w_src_v[i]) begin
                    r_d[i] <= w_src_d[i];
                end
`endif
            end
        end
    end

    // An output cycle is stalled when a beat is presented but not taken.
    assign w_stall_evt = r_v[DEPTH-1] & ~out_ready;

    // Saturating stall counter; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_stall_evt && (r_stall != c_STALL_MAX)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign out_valid    = r_v[DEPTH-1];
    assign out_data     = r_d[DEPTH-1];
    assign occupancy    = r_occ;
    assign stall_cycles = r_stall;

endmodule
`default_nettype wire
